// File: rtl/umi_burst_pack.sv
// UMI transmit packer: captures one request per handshake and emits a header
// beat followed by internally sequenced UW-wide data beats with a last flag.
module umi_burst_pack #(
  parameter int AW = 64,
  parameter int UW = 256,
  parameter int DW = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_opcode,
  input  logic [3:0]                    in_size,
  input  logic [19:0]                   in_user,
  input  logic [$clog2(DW/8):0]         in_len,
  input  logic [AW-1:0]                 in_dstaddr,
  input  logic [AW-1:0]                 in_srcaddr,
  input  logic [DW-1:0]                 in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [UW-1:0]                 out_packet,
  output logic                          out_last
);

  localparam int HDW = UW - 32 - 2 * AW;
  localparam int LW  = $clog2(DW / 8) + 1;
  localparam int NB  = DW / 8;
  localparam int CW  = LW + 3;

  typedef enum logic [1:0] {IDLE, HEAD, BURST} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   data_sh;
  logic [CW-1:0]   rem;

  logic            is_read;
  logic            accept;
  logic            take;
  logic [CW-1:0]   len_ext;
  logic [CW-1:0]   len_eff;
  logic [CW-1:0]   len_bits;
  logic [CW-1:0]   rem_calc;
  logic [DW-1:0]   data_mask;
  logic [UW-1:0]   hdr;

  // Request decode: clamp length, count burst beats, zero bytes past the length
  always_comb begin
    is_read  = (in_opcode[3:0] == 4'h1);
    len_ext  = CW'(in_len);
    len_eff  = (len_ext > CW'(NB)) ? CW'(NB) : len_ext;
    len_bits = len_eff << 3;
    rem_calc = '0;
    if (!is_read && (len_bits > CW'(HDW)))
      rem_calc = (len_bits - CW'(HDW) + CW'(UW - 1)) / CW'(UW);
    data_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (!is_read && (CW'(i) < len_eff))
        data_mask[i*8 +: 8] = in_data[i*8 +: 8];
    end
    hdr = {data_mask[HDW-1:0], in_srcaddr, in_dstaddr, in_user, in_size, in_opcode};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take      = out_valid && out_ready;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (take) state_nxt = (rem == '0) ? IDLE : BURST;
      end
      BURST: begin
        if (take && (rem == CW'(1))) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat sequencing: data_sh always holds the next burst beat in its low UW bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_packet <= '0;
      data_sh    <= '0;
      rem        <= '0;
    end else begin
      in_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid  <= 1'b1;
            out_packet <= hdr;
            out_last   <= (rem_calc == '0);
            rem        <= rem_calc;
            data_sh    <= data_mask >> HDW;
          end
        end
        HEAD: begin
          if (take) begin
            if (rem == '0) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_packet <= data_sh[UW-1:0];
              data_sh    <= data_sh >> UW;
              out_last   <= (rem == CW'(1));
            end
          end
        end
        BURST: begin
          if (take) begin
            if (rem == CW'(1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rem        <= rem - CW'(1);
              out_packet <= data_sh[UW-1:0];
              data_sh    <= data_sh >> UW;
              out_last   <= (rem == CW'(2));
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
